dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- MEM-stage data-memory master for the 5-stage MIPS core.
- Consumes the byte-write mask and lane-replicated store data produced by the EX-stage store-alignment logic (via the EX/MEM register).
- Drives an SRAM-like split-handshake data bus and stalls the pipeline while an access is outstanding.
- Returns sign- or zero-extended load data to WB.

Parameters:
- AW, 32, address width
- DW, 32, data width (fixed 32; byte-lane logic assumes 4 lanes)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_enM  in  1  MEM stage holds a valid instruction
- alucontrolM  in  8  op code (`EXE_*_OP encoding)
- addrM  in  32  effective address
- sig_writeM  in  4  byte-write mask from EX; 0000 for non-store or bad store
- wdataM  in  32  lane-replicated store data
- flushM  in  1  exception/flush of the MEM instruction
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  bus address
- data_wdata  out  32  bus write data
- data_wstrb  out  4  bus byte strobe
- data_addr_ok  in  1  address accepted
- data_data_ok  in  1  data phase complete
- data_rdata  in  32  read data
- mem_stall  out  1  hold IF..MEM
- rdataM  out  32  extended load result
- rdata_valid  out  1  rdataM valid, one-cycle pulse

Behaviour:
- Reset is synchronous and active-high, on a single clock (clk/rst).
- Reset values: state=IDLE; data_req, data_wr, rdata_valid = 0; data_size, data_addr, data_wdata, data_wstrb, rdataM = 0; cancel flag = 0.
- Reset mid-transaction returns to IDLE next edge; an outstanding data_ok after reset is ignored.
- start = mem_enM & !flushM & (load op | sig_writeM != 0).
  - Load ops: LW/LB/LBU/LH/LHU.
  - Store ops with sig_writeM = 0000 issue nothing.
- States:
  - IDLE: on start, latch op, addr[1:0], wr = (sig_writeM != 0), then go to ADDR.
    - Registered bus fields are valid in ADDR.
    - data_addr = addrM.
    - data_size from op, or from mask popcount for stores (1→0, 2→1, 4→2).
    - data_wstrb = sig_writeM; data_wdata = wdataM.
  - ADDR: data_req = 1; all fields held stable until data_addr_ok.
    - addr_ok & data_ok in the same cycle → DONE.
    - addr_ok only → DATA.
  - DATA: data_req = 0; on data_data_ok → DONE.
  - DONE: one cycle. rdataM is registered at entry; rdata_valid = 1 for loads when not cancelled. Then → IDLE. No new start is accepted in DONE.
- mem_stall = (IDLE & start) | ADDR | DATA, all combinational. It is low in DONE, so the pipeline advances at the end of DONE.
- Flush:
  - In IDLE: suppresses start.
  - In ADDR or DATA: sets cancel. The request is never withdrawn. The transaction completes and the result is discarded (rdata_valid stays 0). mem_stall stays high until DONE.
- Load extension on data_rdata, using latched addr[1:0]:
  - LB/LBU: byte lane = addr[1:0], sign/zero extend.
  - LH/LHU: half = addr[1] ? [31:16] : [15:0], sign/zero extend.
  - LW: unchanged.
- The store path does no data manipulation; data and mask arrive pre-aligned.

Optional Feature:
- DMEM_ADDR_ERR_EN defined:
  - Adds outputs adelM and adesM (1 bit each, combinational).
  - adelM for misaligned LW (addr[1:0] != 0) or LH/LHU (addr[0] = 1).
  - adesM for misaligned SW/SH.
  - Either one suppresses start; no bus request is issued.
- Undefined: no ports, no checks.
  - Misaligned loads are issued with the raw address.
  - Misaligned stores issue nothing because sig_writeM = 0000.

Decomposition:
- defines.vh: `EXE_*_OP codes (shared, existing); add state encodings DMEM_IDLE/ADDR/DATA/DONE and size codes DMEM_SZ_B/H/W.
- Sub-module load_extend (combinational): inputs op, addr[1:0], rdata; output rdataM next value.

Test Plan:
- LW at 0x100, addr_ok in cycle 1, data_ok in cycle 3 with rdata 0xDEADBEEF → req high one cycle, size = 2, wstrb = 0, mem_stall high 4 cycles, rdataM = 0xDEADBEEF, rdata_valid pulse in DONE.
- LB at 0x103, rdata 0x80112233 → rdataM = 0xFFFFFF80; LBU → 0x00000080; LH at 0x102 → 0xFFFF8011.
- SB: mask 0100, wdata 0x5A5A5A5A, addr_ok and data_ok in the same cycle → wr = 1, size = 0, wstrb = 0100, ADDR→DONE directly, rdata_valid = 0.
- addr_ok delayed 5 cycles → data_addr, data_wdata, data_wstrb stable and req high throughout; mem_stall high.
- flushM in DATA → data_ok still awaited, rdata_valid = 0, mem_stall low only in DONE; a flushM in IDLE issues no req.
- rst in DATA → next cycle IDLE, req = 0, stall = 0, rdataM = 0.
- With DMEM_ADDR_ERR_EN: LW at 0x102 → adelM = 1, no req.

Source files
------------

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared op codes, FSM states and bus size codes for the MEM-stage data-memory master.
// Optional address-error checking is enabled with DMEM_ADDR_ERR_EN (see dmem_access_ctrl).
package dmem_access_ctrl_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] DMEM_SZ_B = 2'd0;
  localparam logic [1:0] DMEM_SZ_H = 2'd1;
  localparam logic [1:0] DMEM_SZ_W = 2'd2;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_ADDR = 2'd1,
    DMEM_DATA = 2'd2,
    DMEM_DONE = 2'd3
  } dmem_state_e;

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == EXE_LW_OP) || (op == EXE_LB_OP) || (op == EXE_LBU_OP) ||
           (op == EXE_LH_OP) || (op == EXE_LHU_OP);
  endfunction

  function automatic logic [1:0] load_size(input logic [7:0] op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP) return DMEM_SZ_B;
    if (op == EXE_LH_OP || op == EXE_LHU_OP) return DMEM_SZ_H;
    return DMEM_SZ_W;
  endfunction

  // Store masks arrive pre-aligned, so lane count alone fixes the access size.
  function automatic logic [1:0] mask_size(input logic [3:0] mask);
    case (mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return DMEM_SZ_B;
      4'b0011, 4'b1100:                   return DMEM_SZ_H;
      default:                            return DMEM_SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// SRAM-like split-handshake data bus: address phase (req/addr_ok) then data phase (data_ok).
interface dmem_access_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [3:0]    data_wstrb;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_access_ctrl_load_extend.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_extend
  import dmem_access_ctrl_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[8*lo +: 8];
    half_sel = lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      EXE_LB_OP:  data = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: data = {24'h0, byte_sel};
      EXE_LH_OP:  data = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP: data = {16'h0, half_sel};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory master: issues one bus access per load/store and stalls until DONE.
// Define DMEM_ADDR_ERR_EN to add adelM/adesM misalignment outputs that block the access.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_enM,
  input  logic [7:0]    alucontrolM,
  input  logic [AW-1:0] addrM,
  input  logic [3:0]    sig_writeM,
  input  logic [DW-1:0] wdataM,
  input  logic          flushM,
  dmem_access_ctrl_if.master bus,
  output logic          mem_stall,
  output logic [DW-1:0] rdataM,
  output logic          rdata_valid
`ifdef DMEM_ADDR_ERR_EN
  ,
  output logic          adelM,
  output logic          adesM
`endif
);

  dmem_state_e   state, state_next;
  logic [7:0]    op_q;
  logic [1:0]    lo_q;
  logic          cancel;
  logic          wr_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    wstrb_q;
  logic [DW-1:0] ext_data;
  logic          addr_err;
  logic          start;
  logic          fin;

`ifdef DMEM_ADDR_ERR_EN
  assign adelM = mem_enM &
                 (((alucontrolM == EXE_LW_OP) & (addrM[1:0] != 2'b00)) |
                  (((alucontrolM == EXE_LH_OP) | (alucontrolM == EXE_LHU_OP)) & addrM[0]));
  assign adesM = mem_enM &
                 (((alucontrolM == EXE_SW_OP) & (addrM[1:0] != 2'b00)) |
                  ((alucontrolM == EXE_SH_OP) & addrM[0]));
  assign addr_err = adelM | adesM;
`else
  assign addr_err = 1'b0;
`endif

  assign start = mem_enM & ~flushM & ~addr_err &
                 (is_load_op(alucontrolM) | (sig_writeM != 4'b0000));
  assign fin   = ((state == DMEM_ADDR) & bus.data_addr_ok & bus.data_data_ok) |
                 ((state == DMEM_DATA) & bus.data_data_ok);

  assign bus.data_req   = (state == DMEM_ADDR);
  assign bus.data_wr    = wr_q;
  assign bus.data_size  = size_q;
  assign bus.data_addr  = addr_q;
  assign bus.data_wdata = wdata_q;
  assign bus.data_wstrb = wstrb_q;

  always_ff @(posedge clk) begin
    if (rst) state <= DMEM_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    mem_stall  = 1'b0;
    case (state)
      DMEM_IDLE: begin
        mem_stall = start;
        if (start) state_next = DMEM_ADDR;
      end
      DMEM_ADDR: begin
        mem_stall = 1'b1;
        if (bus.data_addr_ok) state_next = bus.data_data_ok ? DMEM_DONE : DMEM_DATA;
      end
      DMEM_DATA: begin
        mem_stall = 1'b1;
        if (bus.data_data_ok) state_next = DMEM_DONE;
      end
      default: state_next = DMEM_IDLE;
    endcase
  end

  load_extend u_load_extend (
    .op    (op_q),
    .lo    (lo_q),
    .rdata (bus.data_rdata),
    .data  (ext_data)
  );

  // A flush after issue never withdraws the request; it only marks the result to be dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      lo_q        <= '0;
      cancel      <= 1'b0;
      wr_q        <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdataM      <= '0;
      rdata_valid <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        DMEM_IDLE: begin
          if (start) begin
            op_q    <= alucontrolM;
            lo_q    <= addrM[1:0];
            cancel  <= 1'b0;
            wr_q    <= (sig_writeM != 4'b0000);
            size_q  <= (sig_writeM != 4'b0000) ? mask_size(sig_writeM) : load_size(alucontrolM);
            addr_q  <= addrM;
            wdata_q <= wdataM;
            wstrb_q <= sig_writeM;
          end
        end
        DMEM_ADDR, DMEM_DATA: begin
          if (flushM) cancel <= 1'b1;
          if (fin && is_load_op(op_q)) begin
            rdataM      <= ext_data;
            rdata_valid <= ~cancel & ~flushM;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Self-checking bench for dmem_access_ctrl: table of load/store transactions plus reset/flush sequences.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          addr_delay;
    int          data_delay;
    int          flush_at;
    logic [1:0]  exp_size;
    logic        exp_wr;
    logic [31:0] exp_rdata;
    logic        exp_valid;
    int          exp_stall;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        valid;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enM;
  logic [7:0]  alucontrolM;
  logic [31:0] addrM;
  logic [3:0]  sig_writeM;
  logic [31:0] wdataM;
  logic        flushM;
  logic        mem_stall;
  logic [31:0] rdataM;
  logic        rdata_valid;
`ifdef DMEM_ADDR_ERR_EN
  logic        adelM;
  logic        adesM;
`endif

  int   compared = 0;
  int   mismatched = 0;
  sb_t  sb[$];
  vec_t vecs[12];

  dmem_access_ctrl_if bus ();

  dmem_access_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .mem_enM     (mem_enM),
    .alucontrolM (alucontrolM),
    .addrM       (addrM),
    .sig_writeM  (sig_writeM),
    .wdataM      (wdataM),
    .flushM      (flushM),
    .bus         (bus.master),
    .mem_stall   (mem_stall),
    .rdataM      (rdataM),
    .rdata_valid (rdata_valid)
`ifdef DMEM_ADDR_ERR_EN
    ,
    .adelM       (adelM),
    .adesM       (adesM)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idleInputs();
    mem_enM          = 1'b0;
    flushM           = 1'b0;
    alucontrolM      = 8'h00;
    addrM            = 32'h0;
    sig_writeM       = 4'b0000;
    wdataM           = 32'h0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
  endtask

  // Drives one transaction from IDLE; the bus responder follows the vector's delays.
  task automatic applyStimulus(input vec_t v);
    int  cyc, req_cnt, data_cnt, stall_cnt;
    bit  accepted, done;
    sb_t exp_e, got_e;
    exp_e.rdata = v.exp_rdata;
    exp_e.valid = v.exp_valid;
    sb.push_back(exp_e);
    mem_enM        = 1'b1;
    alucontrolM    = v.op;
    addrM          = v.addr;
    sig_writeM     = v.mask;
    wdataM         = v.wdata;
    bus.data_rdata = v.rdata;
    cyc = 0; req_cnt = 0; data_cnt = 0; stall_cnt = 0; accepted = 0; done = 0;
    while (!done && cyc < 60) begin
      flushM = (cyc == v.flush_at);
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      if (bus.data_req) begin
        checkOutput("bus_addr", bus.data_addr, v.addr);
        checkOutput("bus_wdata", bus.data_wdata, v.wdata);
        checkOutput("bus_wstrb", {28'h0, bus.data_wstrb}, {28'h0, v.mask});
        checkOutput("bus_size_wr", {29'h0, bus.data_size, bus.data_wr}, {29'h0, v.exp_size, v.exp_wr});
        if (req_cnt == v.addr_delay) begin
          bus.data_addr_ok = 1'b1;
          bus.data_data_ok = (v.data_delay == 0);
          accepted = 1;
        end
        req_cnt++;
      end else if (accepted) begin
        data_cnt++;
        bus.data_data_ok = (data_cnt == v.data_delay);
      end
      #1;
      if (mem_stall) begin
        stall_cnt++;
      end else if (cyc > 0) begin
        done = 1;
        checkOutput("done_req", {31'h0, bus.data_req}, 32'h0);
        checkOutput("stall_cycles", stall_cnt, v.exp_stall);
        if (sb.size() == 0) begin
          checkOutput("scoreboard_empty", 32'h1, 32'h0);
        end else begin
          got_e = sb.pop_front();
          checkOutput("rdata_valid", {31'h0, rdata_valid}, {31'h0, got_e.valid});
          if (got_e.valid) checkOutput("rdataM", rdataM, got_e.rdata);
        end
        idleInputs();
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      checkOutput("txn_timeout", 32'h1, 32'h0);
      idleInputs();
      sb.delete();
    end
  endtask

  initial begin
    vecs[0]  = '{EXE_LW_OP,  32'h100, 4'b0000, 32'h0,        32'hDEADBEEF, 0, 2, -1, DMEM_SZ_W, 1'b0, 32'hDEADBEEF, 1'b1, 4};
    vecs[1]  = '{EXE_LB_OP,  32'h103, 4'b0000, 32'h0,        32'h80112233, 0, 1, -1, DMEM_SZ_B, 1'b0, 32'hFFFFFF80, 1'b1, 3};
    vecs[2]  = '{EXE_LBU_OP, 32'h103, 4'b0000, 32'h0,        32'h80112233, 0, 0, -1, DMEM_SZ_B, 1'b0, 32'h00000080, 1'b1, 2};
    vecs[3]  = '{EXE_LH_OP,  32'h102, 4'b0000, 32'h0,        32'h80112233, 1, 1, -1, DMEM_SZ_H, 1'b0, 32'hFFFF8011, 1'b1, 4};
    vecs[4]  = '{EXE_LHU_OP, 32'h100, 4'b0000, 32'h0,        32'h12348001, 0, 1, -1, DMEM_SZ_H, 1'b0, 32'h00008001, 1'b1, 3};
    vecs[5]  = '{EXE_LB_OP,  32'h101, 4'b0000, 32'h0,        32'h11227F44, 0, 0, -1, DMEM_SZ_B, 1'b0, 32'h0000007F, 1'b1, 2};
    vecs[6]  = '{EXE_SB_OP,  32'h102, 4'b0100, 32'h5A5A5A5A, 32'h0,        0, 0, -1, DMEM_SZ_B, 1'b1, 32'h0,        1'b0, 2};
    vecs[7]  = '{EXE_SW_OP,  32'h200, 4'b1111, 32'hCAFEF00D, 32'h0,        5, 1, -1, DMEM_SZ_W, 1'b1, 32'h0,        1'b0, 8};
    vecs[8]  = '{EXE_SH_OP,  32'h302, 4'b1100, 32'hBEEFBEEF, 32'h0,        2, 0, -1, DMEM_SZ_H, 1'b1, 32'h0,        1'b0, 4};
    vecs[9]  = '{EXE_LW_OP,  32'h400, 4'b0000, 32'h0,        32'h01234567, 0, 3,  2, DMEM_SZ_W, 1'b0, 32'h0,        1'b0, 5};
    vecs[10] = '{EXE_LH_OP,  32'h100, 4'b0000, 32'h0,        32'h00008000, 2, 1,  1, DMEM_SZ_H, 1'b0, 32'h0,        1'b0, 5};
    vecs[11] = '{EXE_LW_OP,  32'h104, 4'b0000, 32'h0,        32'hA5A50F0F, 3, 0, -1, DMEM_SZ_W, 1'b0, 32'hA5A50F0F, 1'b1, 5};

    idleInputs();
    bus.data_rdata = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_req", {31'h0, bus.data_req}, 32'h0);
    checkOutput("rst_wr", {31'h0, bus.data_wr}, 32'h0);
    checkOutput("rst_size", {30'h0, bus.data_size}, 32'h0);
    checkOutput("rst_addr", bus.data_addr, 32'h0);
    checkOutput("rst_wdata", bus.data_wdata, 32'h0);
    checkOutput("rst_wstrb", {28'h0, bus.data_wstrb}, 32'h0);
    checkOutput("rst_rdataM", rdataM, 32'h0);
    checkOutput("rst_valid", {31'h0, rdata_valid}, 32'h0);
    checkOutput("rst_stall", {31'h0, mem_stall}, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) applyStimulus(vecs[i]);

    // Flush in IDLE suppresses the access entirely.
    mem_enM = 1'b1; flushM = 1'b1; alucontrolM = EXE_LW_OP; addrM = 32'h600;
    #1;
    checkOutput("flush_idle_stall", {31'h0, mem_stall}, 32'h0);
    @(posedge clk); #1;
    checkOutput("flush_idle_req", {31'h0, bus.data_req}, 32'h0);
    idleInputs();

    // A store whose mask was cleared upstream issues nothing.
    mem_enM = 1'b1; alucontrolM = EXE_SW_OP; addrM = 32'h202; sig_writeM = 4'b0000;
    #1;
    checkOutput("zero_mask_stall", {31'h0, mem_stall}, 32'h0);
    @(posedge clk); #1;
    checkOutput("zero_mask_req", {31'h0, bus.data_req}, 32'h0);
    idleInputs();

`ifdef DMEM_ADDR_ERR_EN
    mem_enM = 1'b1; alucontrolM = EXE_LW_OP; addrM = 32'h102;
    #1;
    checkOutput("adelM", {31'h0, adelM}, 32'h1);
    checkOutput("adel_stall", {31'h0, mem_stall}, 32'h0);
    @(posedge clk); #1;
    checkOutput("adel_req", {31'h0, bus.data_req}, 32'h0);
    alucontrolM = EXE_SH_OP; addrM = 32'h301; sig_writeM = 4'b0010;
    #1;
    checkOutput("adesM", {31'h0, adesM}, 32'h1);
    @(posedge clk); #1;
    checkOutput("ades_req", {31'h0, bus.data_req}, 32'h0);
    idleInputs();
`else
    applyStimulus('{EXE_LW_OP, 32'h102, 4'b0000, 32'h0, 32'h11111111, 0, 0, -1,
                    DMEM_SZ_W, 1'b0, 32'h11111111, 1'b1, 2});
`endif

    // Reset while waiting in DATA; a late data_ok must be ignored.
    mem_enM = 1'b1; alucontrolM = EXE_LW_OP; addrM = 32'h500; bus.data_rdata = 32'h77777777;
    @(posedge clk); #1;
    checkOutput("rstdata_req", {31'h0, bus.data_req}, 32'h1);
    bus.data_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0;
    checkOutput("rstdata_in_data", {30'h0, mem_stall, bus.data_req}, 32'h2);
    rst = 1'b1; mem_enM = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rstdata_req_after", {31'h0, bus.data_req}, 32'h0);
    checkOutput("rstdata_stall_after", {31'h0, mem_stall}, 32'h0);
    checkOutput("rstdata_rdataM", rdataM, 32'h0);
    bus.data_data_ok = 1'b1;
    @(posedge clk); #1;
    bus.data_data_ok = 1'b0;
    checkOutput("late_ok_valid", {31'h0, rdata_valid}, 32'h0);
    checkOutput("late_ok_rdataM", rdataM, 32'h0);
    checkOutput("late_ok_stall", {31'h0, mem_stall}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
